dcj11_bus_ctrl: RTL
===================

DCJ11_BUS_CTRL -- requirements
Module: dcj11_bus_ctrl

Interface
REQ-001 SHALL have parameter MEM_TOP, default 22'o0157777: highest existing memory address.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 32: sclk cycles allowed for mem_ack before a non-existent-memory (NXM) error.
REQ-003 SHALL have port clk, in, 1: single clock, the 54 MHz PLL clock; all logic on its rising edge.
REQ-004 SHALL have port rst, in, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports aio[3:0], bs[1:0], dal_hi[5:0] and dal_lo_in[15:0], all inputs, asynchronous: DCJ11 cycle code, bank select, DAL<21:16> and DAL<15:0>.
REQ-006 SHALL have ports ale_n, strb_n and bufctl_n, in, 1 each, asynchronous: DCJ11 strobes.
REQ-007 SHALL have ports mem_addr[21:0], mem_wdata[15:0] and mem_be[1:0], outputs: request address, write data and byte enables (bit0 = low byte).
REQ-008 SHALL have ports mem_rd and mem_wr, out, 1 each: one-cycle request pulses.
REQ-009 SHALL have ports mem_ack (in, 1) and mem_rdata[15:0] (in): memory completion and read data, valid together.
REQ-010 SHALL have ports rdata_out[15:0] and rdata_valid (out, 1): read data for the DAL driver.
REQ-011 SHALL have ports nxm (out, 1) and busy (out, 1): NXM flag, and FSM not in IDLE.

Function
REQ-012 SHALL pass ale_n, strb_n and bufctl_n through 2-flop synchronizers plus one delay flop, all reset to 1.
REQ-013 SHALL derive ale_fall, ale_rise and strb_fall from the synchronized signals; each is 1 cycle wide.
REQ-014 SHALL use FSM states IDLE, RD_REQ, RD_WAIT, RD_HOLD, WR_DATA, WR_WAIT, WR_DONE, IGNORE and NXM_ST.
REQ-015 On ale_fall in IDLE, SHALL latch aio, bs and mem_addr = {dal_hi, dal_lo_in}; DAL is system-guaranteed stable for at least 4 sclk after the ale_n fall.
REQ-016 Read class SHALL be aio in {1000, 1001, 1010, 1011, 1100}; RMW codes are read-only here (the write half arrives as a separate cycle).
REQ-017 Write class SHALL be aio in {0001, 0011}; all other codes, and bs = SYS or INT, SHALL go to IGNORE.
REQ-018 A read or write with bs = EXT, or with bs = MEM and mem_addr > MEM_TOP, SHALL go to NXM_ST with no mem request; the comparison is unsigned, 22-bit.
REQ-019 Otherwise, reads SHALL go to RD_REQ and writes to WR_DATA.
REQ-020 RD_REQ SHALL assert mem_rd for exactly 1 cycle, then go to RD_WAIT; mem_rd rises 1 cycle after ale_fall.
REQ-021 RD_WAIT: on mem_ack, SHALL register mem_rdata into rdata_out, set rdata_valid next cycle, and go to RD_HOLD.
REQ-022 WR_DATA: on strb_fall, SHALL latch dal_lo_in into mem_wdata and go to WR_WAIT with a 1-cycle mem_wr pulse.
REQ-023 mem_be SHALL be 2'b11 for a word write, 2'b01 for a byte write at an even address, and 2'b10 for a byte write at an odd address.
REQ-024 WR_WAIT: on mem_ack, SHALL go to WR_DONE.
REQ-025 An 8-bit wait counter SHALL clear on entry to RD_WAIT or WR_WAIT, increment each cycle without ack, and on reaching ACK_TIMEOUT go to NXM_ST.
REQ-026 nxm SHALL be 1 exactly while in NXM_ST.
REQ-027 ale_rise SHALL return any state to IDLE and clear rdata_valid and nxm; it has priority over mem_ack and the timeout in the same cycle, and that ack is discarded.
REQ-028 ale_fall outside IDLE SHALL be ignored.
REQ-029 A mem_ack arriving outside RD_WAIT or WR_WAIT (a late ack after an abort) SHALL be ignored.
REQ-030 rdata_out SHALL hold its value until the next read ack; mem_addr, mem_wdata and mem_be SHALL hold until the next latch.
REQ-031 busy SHALL be 1 in every state except IDLE.

Reset
REQ-032 While rst = 1, the FSM SHALL be in IDLE, and mem_rd, mem_wr, rdata_valid, nxm and busy SHALL be 0.
REQ-033 While rst = 1, mem_addr, mem_wdata and rdata_out SHALL be 0, mem_be SHALL be 2'b00, the wait counter SHALL be 0, and the synchronizer flops SHALL be 1.
REQ-034 Reset asserted mid-cycle SHALL abort with no further mem pulses; after release, the block SHALL wait for a fresh ale_fall.

Verification
REQ-035 Read: aio = 1001, bs = 00, addr = 22'o001000; mem_ack with data 16'o012345 three cycles after mem_rd -> one mem_rd pulse, mem_addr = 22'o001000, rdata_out = 16'o012345, rdata_valid = 1 until ale_rise.
REQ-036 Byte write: aio = 0011, addr = 22'o000401, DAL = 16'h00A5 at strb_fall -> one mem_wr pulse, mem_be = 2'b10, mem_wdata = 16'h00A5; WR_DONE, then IDLE on ale_rise.
REQ-037 NXM by address: aio = 1000, bs = 00, addr = 22'o0160000 -> nxm = 1, no mem_rd; nxm = 0 after ale_rise. Same for bs = 10 at any address.
REQ-038 Timeout: a valid read with mem_ack never asserted -> nxm rises exactly ACK_TIMEOUT cycles after entry to RD_WAIT.
REQ-039 Abort: ale_rise in RD_WAIT, then mem_ack the next cycle -> IDLE, rdata_valid stays 0, late ack ignored, and the next cycle proceeds normally.
REQ-040 GP/reset: aio = 1110 -> IGNORE with no mem pulses; rst asserted during WR_WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/dcj11_bus_ctrl.sv
// DCJ11 DAL bus cycle controller: synchronizes the CPU strobes, decodes each bus
// cycle and turns it into single-cycle memory read/write requests with NXM detection.
module dcj11_bus_ctrl #(
    parameter logic [21:0] MEM_TOP     = 22'o0157777,
    parameter int          ACK_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  aio,
    input  logic [1:0]  bs,
    input  logic [5:0]  dal_hi,
    input  logic [15:0] dal_lo_in,
    input  logic        ale_n,
    input  logic        strb_n,
    input  logic        bufctl_n,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] rdata_out,
    output logic        rdata_valid,
    output logic        nxm,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, RD_REQ, RD_WAIT, RD_HOLD, WR_DATA, WR_WAIT, WR_DONE, IGNORE, NXM_ST
    } state_t;

    localparam logic [1:0] BS_MEM = 2'b00;
    localparam logic [1:0] BS_EXT = 2'b10;
    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [3:0]  aio_q;
    logic        ale_s1, ale_s2, ale_d;
    logic        strb_s1, strb_s2, strb_d;
    logic        buf_s1, buf_s2, buf_d;
    logic        ale_fall, ale_rise, strb_fall;
    logic        is_rd, is_wr;
    logic [21:0] dal_addr;

    // Strobes are asynchronous to clk: two flops to settle, a third to find edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {ale_s1, ale_s2, ale_d}    <= 3'b111;
            {strb_s1, strb_s2, strb_d} <= 3'b111;
            {buf_s1, buf_s2, buf_d}    <= 3'b111;
        end else begin
            {ale_s1, ale_s2, ale_d}    <= {ale_n, ale_s1, ale_s2};
            {strb_s1, strb_s2, strb_d} <= {strb_n, strb_s1, strb_s2};
            {buf_s1, buf_s2, buf_d}    <= {bufctl_n, buf_s1, buf_s2};
        end
    end

    assign ale_fall  = ale_d & ~ale_s2;
    assign ale_rise  = ~ale_d & ale_s2;
    assign strb_fall = strb_d & ~strb_s2;
    assign dal_addr  = {dal_hi, dal_lo_in};
    assign is_rd     = aio inside {4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};
    assign is_wr     = aio inside {4'b0001, 4'b0011};

    // ale_rise ends every cycle and outranks a same-cycle ack or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            aio_q       <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= 2'b00;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            rdata_out   <= '0;
            rdata_valid <= 1'b0;
            nxm         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (ale_rise) begin
                state       <= IDLE;
                rdata_valid <= 1'b0;
                nxm         <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (ale_fall) begin
                        mem_addr <= dal_addr;
                        aio_q    <= aio;
                        busy     <= 1'b1;
                        if (!(is_rd || is_wr) || (bs != BS_MEM && bs != BS_EXT)) begin
                            state <= IGNORE;
                        end else if (bs == BS_EXT || dal_addr > MEM_TOP) begin
                            state <= NXM_ST;
                            nxm   <= 1'b1;
                        end else if (is_rd) begin
                            state  <= RD_REQ;
                            mem_rd <= 1'b1;
                        end else begin
                            state <= WR_DATA;
                        end
                    end
                    RD_REQ: begin
                        state    <= RD_WAIT;
                        wait_cnt <= '0;
                    end
                    RD_WAIT: if (mem_ack) begin
                        rdata_out   <= mem_rdata;
                        rdata_valid <= 1'b1;
                        state       <= RD_HOLD;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= NXM_ST;
                        nxm   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                    WR_DATA: if (strb_fall) begin
                        mem_wdata <= dal_lo_in;
                        mem_be    <= (aio_q == 4'b0001) ? 2'b11 :
                                     (mem_addr[0] ? 2'b10 : 2'b01);
                        mem_wr    <= 1'b1;
                        state     <= WR_WAIT;
                        wait_cnt  <= '0;
                    end
                    WR_WAIT: if (mem_ack) begin
                        state <= WR_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= NXM_ST;
                        nxm   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
